// File: rtl/pcpu_intr_ctrl.sv
// Multi-channel interrupt controller for the pipelined CPU: synchronised request
// lines, per-channel mask and edge/level mode, fixed priority with nesting, INT/Inta handshake.
module pcpu_intr_ctrl #(
  parameter int          N_IRQ      = 8,
  parameter int          ID_W       = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0008,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0004
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [N_IRQ-1:0] irq,
  output logic             intr,
  input  logic             inta,
  output logic [31:0]      vector,
  output logic [ID_W-1:0]  irq_id,
  input  logic [2:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam logic [2:0] ADDR_MASK   = 3'd0;
  localparam logic [2:0] ADDR_PEND   = 3'd1;
  localparam logic [2:0] ADDR_MODE   = 3'd2;
  localparam logic [2:0] ADDR_EOI    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [N_IRQ-1:0] ONE_HOT0 = N_IRQ'(1);

  // Lowest set index wins; returns 0 for an empty vector (callers test emptiness).
  function automatic logic [ID_W-1:0] prio_idx(input logic [N_IRQ-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = v[i] ? ID_W'(i) : idx;
    end
    return idx;
  endfunction

  logic [N_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] mode_q, mode_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic             intr_q, intr_d;
  logic             spur_q, spur_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [31:0]      vector_q, vector_d;

  logic [N_IRQ-1:0] elig_s, rise_s, w1c_s, eoi_clr_s, ack_set_s, to_edge_s, edge_pend_s;
  logic [ID_W-1:0]  cand_s, top_s;
  logic             ack_s, spur_set_s, spur_clr_s;
  logic             unused_s;

  assign unused_s = ^wdata;

  // Next-state logic for channel state, acknowledge and register writes.
  always_comb begin
    elig_s     = pending_q & ~mask_q;
    cand_s     = prio_idx(elig_s);
    top_s      = prio_idx(isr_q);
    rise_s     = s2_q & ~s3_q;
    ack_s      = inta & intr_q & (|elig_s);
    spur_set_s = inta & ~ack_s;
    spur_clr_s = we && (addr == ADDR_STATUS) && wdata[31];

    mask_d = (we && (addr == ADDR_MASK)) ? wdata[N_IRQ-1:0] : mask_q;
    mode_d = (we && (addr == ADDR_MODE)) ? wdata[N_IRQ-1:0] : mode_q;
    w1c_s  = (we && (addr == ADDR_PEND)) ? wdata[N_IRQ-1:0] : '0;

    // EOI retires the old top before the acknowledged channel is added.
    eoi_clr_s = (we && (addr == ADDR_EOI) && (|isr_q)) ? (ONE_HOT0 << top_s) : '0;
    ack_set_s = ack_s ? (ONE_HOT0 << cand_s) : '0;
    isr_d     = (isr_q & ~eoi_clr_s) | ack_set_s;

    // A fresh edge beats a same-cycle clear; level channels just mirror the line.
    to_edge_s   = mode_d & ~mode_q;
    edge_pend_s = (pending_q & ~w1c_s & ~ack_set_s) | rise_s;
    pending_d   = ((mode_q & edge_pend_s) | (~mode_q & s2_q)) & ~to_edge_s;

    if (ack_s) begin
      intr_d   = 1'b0;
      irq_id_d = cand_s;
      vector_d = VEC_BASE + (32'(cand_s) * VEC_STRIDE);
    end else begin
      intr_d   = (|elig_s) && ((isr_q == '0) || (cand_s < top_s));
      irq_id_d = irq_id_q;
      vector_d = vector_q;
    end

    spur_d = spur_set_s | (spur_q & ~spur_clr_s);
  end

  // State registers with immediate reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      mask_q    <= '1;
      mode_q    <= '0;
      pending_q <= '0;
      isr_q     <= '0;
      intr_q    <= 1'b0;
      spur_q    <= 1'b0;
      irq_id_q  <= '0;
      vector_q  <= VEC_BASE;
    end else begin
      s1_q      <= irq;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      isr_q     <= isr_d;
      intr_q    <= intr_d;
      spur_q    <= spur_d;
      irq_id_q  <= irq_id_d;
      vector_q  <= vector_d;
    end
  end

  // Register read mux; unused high bits and spare addresses read zero.
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr)
      ADDR_MASK:   rdata = 32'(mask_q);
      ADDR_PEND:   rdata = 32'(pending_q);
      ADDR_MODE:   rdata = 32'(mode_q);
      ADDR_EOI:    rdata = 32'(isr_q);
      ADDR_STATUS: begin
        rdata     = 32'(irq_id_q);
        rdata[31] = spur_q;
      end
      default:     rdata = 32'h0000_0000;
    endcase
  end

  assign intr   = intr_q;
  assign irq_id = irq_id_q;
  assign vector = vector_q;

endmodule
